// File: rtl/prog_loader.sv
// Program memory boot loader: receives a framed byte stream
// and writes 16-bit words into program memory from address 0.
module prog_loader #(
   parameter int WIDTH  = 16,
   parameter int NWORDS = 1024,
   localparam int AW    = $clog2(NWORDS)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [7:0]       byte_in,
   input  logic             byte_valid,
   output logic             byte_ready,
   input  logic [AW-1:0]    cpu_a,
   output logic [AW-1:0]    mem_a,
   output logic             mem_we,
   output logic [WIDTH-1:0] mem_wd,
   output logic             cpu_hold,
   output logic             busy,
   output logic             done,
   output logic             error,
   output logic [15:0]      words_loaded
);

   typedef enum logic [3:0] {
      S_IDLE, S_LEN_HI, S_LEN_LO, S_DATA_HI, S_DATA_LO,
      S_WRITE, S_CHECK, S_DONE, S_ERROR
   } state_t;

   state_t           state_q, state_d;
   logic [15:0]      len_q, len_d;
   logic [15:0]      cnt_q, cnt_d;
   logic [AW-1:0]    waddr_q, waddr_d;
   logic [7:0]       chk_q, chk_d;
   logic [WIDTH-1:0] wd_q, wd_d;
   logic             acc;
   logic [16:0]      len_new;

   assign acc     = byte_valid && byte_ready;
   assign len_new = {1'b0, len_q[15:8], byte_in};

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= S_IDLE;
         len_q   <= '0;
         cnt_q   <= '0;
         waddr_q <= '0;
         chk_q   <= '0;
         wd_q    <= '0;
      end else begin
         state_q <= state_d;
         len_q   <= len_d;
         cnt_q   <= cnt_d;
         waddr_q <= waddr_d;
         chk_q   <= chk_d;
         wd_q    <= wd_d;
      end
   end

   always_comb begin
      state_d = state_q;
      len_d   = len_q;
      cnt_d   = cnt_q;
      waddr_d = waddr_q;
      chk_d   = chk_q;
      wd_d    = wd_q;
      unique case (state_q)
         S_IDLE, S_DONE, S_ERROR: begin
            if (start) begin
               state_d = S_LEN_HI;
               cnt_d   = '0;
               waddr_d = '0;
               chk_d   = '0;
            end
         end
         S_LEN_HI: begin
            if (acc) begin
               len_d   = {byte_in, len_q[7:0]};
               state_d = S_LEN_LO;
            end
         end
         S_LEN_LO: begin
            if (acc) begin
               len_d = len_new[15:0];
               if (len_new > 17'(NWORDS))
                  state_d = S_ERROR;
               else if (len_new == '0)
                  state_d = S_CHECK;
               else
                  state_d = S_DATA_HI;
            end
         end
         S_DATA_HI: begin
            if (acc) begin
               wd_d[15:8] = byte_in;
               chk_d      = chk_q ^ byte_in;
               state_d    = S_DATA_LO;
            end
         end
         S_DATA_LO: begin
            if (acc) begin
               wd_d[7:0] = byte_in;
               chk_d     = chk_q ^ byte_in;
               state_d   = S_WRITE;
            end
         end
         S_WRITE: begin
            waddr_d = waddr_q + AW'(1);
            cnt_d   = cnt_q + 16'd1;
            state_d = (cnt_q + 16'd1 == len_q) ? S_CHECK : S_DATA_HI;
         end
         S_CHECK: begin
            if (acc)
               state_d = (byte_in == chk_q) ? S_DONE : S_ERROR;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      busy       = 1'b0;
      byte_ready = 1'b0;
      done       = 1'b0;
      error      = 1'b0;
      unique case (state_q)
         S_LEN_HI, S_LEN_LO, S_DATA_HI, S_DATA_LO, S_CHECK: begin
            busy       = 1'b1;
            byte_ready = 1'b1;
         end
         S_WRITE: busy  = 1'b1;
         S_DONE:  done  = 1'b1;
         S_ERROR: error = 1'b1;
         default: ;
      endcase
   end

   // Reset gates the strobe so a WRITE caught by reset never lands.
   assign mem_we       = (state_q == S_WRITE) && reset;
   assign mem_a        = busy ? waddr_q : cpu_a;
   assign mem_wd       = wd_q;
   assign cpu_hold     = busy || error;
   assign words_loaded = cnt_q;

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader with a simple memory model
// and hand-computed expected frames.
module tb_prog_loader;

   localparam int AW = 10;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          start = 1'b0;
   logic [7:0]    byte_in = 8'h00;
   logic          byte_valid = 1'b0;
   logic          byte_ready;
   logic [AW-1:0] cpu_a = '0;
   logic [AW-1:0] mem_a;
   logic          mem_we;
   logic [15:0]   mem_wd;
   logic          cpu_hold, busy, done, error;
   logic [15:0]   words_loaded;

   int checks = 0;
   int failures = 0;
   int we_cnt = 0;
   int w0;
   logic [15:0] mem [0:1023];

   prog_loader #(.WIDTH(16), .NWORDS(1024)) dut (
      .clk(clk), .reset(reset), .start(start),
      .byte_in(byte_in), .byte_valid(byte_valid),
      .byte_ready(byte_ready), .cpu_a(cpu_a), .mem_a(mem_a),
      .mem_we(mem_we), .mem_wd(mem_wd), .cpu_hold(cpu_hold),
      .busy(busy), .done(done), .error(error),
      .words_loaded(words_loaded)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (mem_we) begin
         mem[mem_a] <= mem_wd;
         we_cnt <= we_cnt + 1;
      end
   end

   task automatic chk(input string tag,
                      input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic pulse_start();
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
   endtask

   task automatic send(input logic [7:0] b);
      int n = 0;
      byte_in = b;
      byte_valid = 1'b1;
      while (!byte_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!byte_ready) chk("ready_timeout", 0, 1);
      @(negedge clk);
      byte_valid = 1'b0;
   endtask

   task automatic send_st(input logic [7:0] b);
      byte_valid = 1'b0;
      repeat ($urandom_range(0, 3)) @(negedge clk);
      send(b);
   endtask

   initial begin
      cpu_a = 10'h005;
      repeat (2) @(negedge clk);
      chk("rst_mem_a", mem_a, 10'h005);
      chk("rst_hold", cpu_hold, 0);
      chk("rst_ready", byte_ready, 0);
      chk("rst_flags", {busy, done, error, mem_we}, 0);
      chk("rst_words", words_loaded, 0);
      chk("rst_wd", mem_wd, 0);
      reset = 1'b1;
      @(negedge clk);
      chk("idle_mem_a", mem_a, 10'h005);
      chk("idle_hold", cpu_hold, 0);

      // good 2-word frame
      pulse_start();
      chk("start_busy", busy, 1);
      chk("start_ready", byte_ready, 1);
      chk("start_mem_a", mem_a, 0);
      chk("start_hold", cpu_hold, 1);
      w0 = we_cnt;
      send(8'h00); send(8'h02);
      send(8'h12); send(8'h34);
      chk("write_we", mem_we, 1);
      chk("write_ready", byte_ready, 0);
      chk("write_wd", mem_wd, 16'h1234);
      send(8'hAB); send(8'hCD); send(8'h40);
      chk("good_done", done, 1);
      chk("good_err", error, 0);
      chk("good_words", words_loaded, 2);
      chk("good_hold", cpu_hold, 0);
      chk("good_mem0", mem[0], 16'h1234);
      chk("good_mem1", mem[1], 16'hABCD);
      chk("good_wecnt", we_cnt - w0, 2);
      chk("good_mem_a", mem_a, 10'h005);

      // bad checksum
      pulse_start();
      chk("restart_done", done, 0);
      w0 = we_cnt;
      send(8'h00); send(8'h02);
      send(8'h12); send(8'h34);
      send(8'hAB); send(8'hCD); send(8'h41);
      chk("bad_err", error, 1);
      chk("bad_done", done, 0);
      chk("bad_hold", cpu_hold, 1);
      chk("bad_wecnt", we_cnt - w0, 2);
      chk("bad_mem_a", mem_a, 10'h005);

      // good frame after error
      pulse_start();
      chk("clr_err", error, 0);
      send(8'h00); send(8'h01);
      send(8'hBE); send(8'hEF); send(8'h51);
      chk("rec_done", done, 1);
      chk("rec_mem0", mem[0], 16'hBEEF);
      chk("rec_words", words_loaded, 1);

      // overflow LEN = 1025
      pulse_start();
      w0 = we_cnt;
      send(8'h04); send(8'h01);
      chk("ovf_err", error, 1);
      chk("ovf_ready", byte_ready, 0);
      chk("ovf_busy", busy, 0);
      chk("ovf_wecnt", we_cnt - w0, 0);

      // LEN = 1024 is still accepted
      pulse_start();
      send(8'h04); send(8'h00);
      chk("max_err", error, 0);
      chk("max_ready", byte_ready, 1);
      @(negedge clk) reset = 1'b0;
      @(negedge clk) reset = 1'b1;

      // zero length
      pulse_start();
      send(8'h00); send(8'h00); send(8'h00);
      chk("zero_done", done, 1);
      chk("zero_words", words_loaded, 0);

      // stalled 1-word frame with start pulse mid-load
      pulse_start();
      send_st(8'h00); send_st(8'h01);
      pulse_start();
      chk("mid_start_busy", busy, 1);
      send_st(8'h5A); send_st(8'hA5); send_st(8'hFF);
      chk("stall_done", done, 1);
      chk("stall_mem0", mem[0], 16'h5AA5);
      chk("stall_words", words_loaded, 1);

      // reset during WRITE of the third word
      pulse_start();
      send(8'h00); send(8'h05);
      send(8'h11); send(8'h11);
      send(8'h22); send(8'h22);
      send(8'h33); send(8'h33);
      chk("pre_rst_we", mem_we, 1);
      w0 = we_cnt;
      reset = 1'b0;
      #1;
      chk("rst_we_gated", mem_we, 0);
      @(negedge clk);
      chk("midrst_wecnt", we_cnt - w0, 0);
      chk("midrst_busy", busy, 0);
      chk("midrst_hold", cpu_hold, 0);
      chk("midrst_words", words_loaded, 0);
      chk("midrst_mem_a", mem_a, 10'h005);
      reset = 1'b1;
      @(negedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/prog_loader.md
# prog_loader

Boot/load controller for the CPU program memory (16-bit words, NWORDS deep). It receives a framed byte stream (word count, data words, XOR checksum) and writes the words into program memory starting at address 0. While loading, it holds the CPU and takes over the memory address bus. When idle, the CPU fetch address passes straight through. The block sits between the byte source (UART/debug link), the program memory and the CPU core.

## Interface
- WIDTH, 16: program word width; fixed at 16 (two bytes per word).
- NWORDS, 1024: program memory depth; address width AW = $clog2(NWORDS).
- clk  in  1  single system clock; everything updates on the rising edge.
- reset  in  1  synchronous, active-low reset (0 = reset, sampled on the rising clk edge).
- start  in  1  one-cycle request to begin a load; honoured only in IDLE, DONE or ERROR.
- byte_in  in  8  incoming stream byte.
- byte_valid  in  1  byte_in is valid.
- byte_ready  out  1  loader can accept a byte this cycle.
- cpu_a  in  AW  CPU fetch address.
- mem_a  out  AW  program memory address: cpu_a when not busy, otherwise the write address.
- mem_we  out  1  program memory write enable.
- mem_wd  out  16  program memory write data.
- cpu_hold  out  1  stalls the CPU (PC frozen) while loading or after a failed load.
- busy  out  1  load in progress.
- done  out  1  last load succeeded; level signal, cleared by start or reset.
- error  out  1  last load failed; level signal, cleared by start or reset.
- words_loaded  out  16  number of words written in the current or last load.

## Operation
- Frame format, MSB byte first: LEN_HI, LEN_LO, then LEN × (DATA_HI, DATA_LO), then CHK. CHK is the XOR of all data bytes (the length bytes are excluded).
- Byte transfer: a byte is accepted when byte_valid && byte_ready are both high on a rising edge.
- States: IDLE, LEN_HI, LEN_LO, DATA_HI, DATA_LO, WRITE, CHECK, DONE, ERROR.
- IDLE/DONE/ERROR + start → LEN_HI. This transition clears done, error, words_loaded, the write address and the checksum accumulator.
- LEN_HI: on accept, latch the upper byte → LEN_LO.
- LEN_LO: on accept, latch the lower byte. Then:
  - if LEN > NWORDS → ERROR;
  - if LEN == 0 → CHECK;
  - otherwise → DATA_HI.
- DATA_HI: on accept, latch byte into mem_wd[15:8], XOR it into the checksum → DATA_LO.
- DATA_LO: on accept, latch byte into mem_wd[7:0], XOR it into the checksum → WRITE.
- WRITE: mem_we = 1 for exactly this cycle, with mem_a = write address. On the next edge:
  - write address += 1 and words_loaded += 1;
  - if words_loaded + 1 == LEN → CHECK, else → DATA_HI.
- CHECK: on accept, compare byte_in with the checksum. Match → DONE; mismatch → ERROR.
- DONE: done = 1, cpu_hold = 0, mem_a = cpu_a.
- ERROR: error = 1, cpu_hold = 1 (the CPU must not run a partial image), mem_a = cpu_a.
- The write address is AW bits wide. The LEN ≤ NWORDS check guarantees it never wraps during a load.
- start is ignored while busy. There is no abort except reset.
- Memory content written before an error is left in place (no rollback).

## Timing
- Reset values: state IDLE, byte_ready 0, mem_we 0, mem_wd 0, cpu_hold 0, busy 0, done 0, error 0, words_loaded 0. mem_a = cpu_a. The CPU runs the resident image.
- Reset mid-load: the next edge forces the reset values. A WRITE in progress is suppressed (mem_we is 0 in the reset cycle).
- busy = 1 and cpu_hold = 1 in every state from LEN_HI to CHECK inclusive.
- byte_ready = 1 in LEN_HI, LEN_LO, DATA_HI, DATA_LO and CHECK. It is 0 in WRITE, IDLE, DONE and ERROR.
- Throughput: at most one word every 3 cycles with byte_valid held high (HI, LO, WRITE).
- Minimum frame time for LEN = N: 3 + 3N cycles from the first accepted byte to DONE/ERROR.
- start is taken on the edge where it is sampled high. byte_ready rises on the following cycle.
- done/error assert the cycle after the accepting edge in CHECK (or LEN_LO on overflow). cpu_hold drops in that same cycle on success.
- mem_a switches to the write address on the same edge that busy rises and stays there until busy falls. This is a combinational mux on the registered busy.

## Test plan
- Reset then idle: hold reset = 0 for 2 cycles, release, drive cpu_a = 0x05 → mem_a = 0x05, cpu_hold = 0, byte_ready = 0, all flags 0.
- Good 2-word load: start, bytes 00 02 12 34 AB CD 40 (0x12^0x34^0xAB^0xCD = 0x40) → writes 0x1234@0 and 0xABCD@1, one mem_we cycle each, then done = 1, words_loaded = 2, cpu_hold = 0.
- Bad checksum: same frame with CHK = 0x41 → both words written, then error = 1, done = 0, cpu_hold stays 1. A following good frame after start clears error and ends in done.
- Length overflow with NWORDS = 1024: bytes 04 01 → error the cycle after LEN_LO, no mem_we, byte_ready = 0.
- Zero length and stalls: bytes 00 00 00 → done with words_loaded = 0. Then a 1-word frame with byte_valid toggling randomly → same memory contents as without stalls; start pulsed mid-load is ignored.
- Reset mid-load: assert reset during WRITE of word 3 → mem_we = 0 in that cycle, state returns to IDLE, busy = 0, cpu_hold = 0, words_loaded = 0.
